count_monitor: RTL and testbench
================================

COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 Parameter N, default 9: counter modulus; the legal count sequence is 0..N-1, then wraps to 0.
REQ-002 Parameter DWIDTH, default 4: width of the observed count; N SHALL be at most 2^DWIDTH.
REQ-003 Parameter LOCK_LEN, default 3: number of consecutive correct increments required to reach lock; legal range 1..15.
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1: reset, synchronous and active-high.
REQ-006 Port sample_en  input  1: when high, data_in is sampled on this edge.
REQ-007 Port data_in  input  DWIDTH: observed count value, driven by the counter under observation.
REQ-008 Port locked  output  1: high while the monitor is in LOCKED.
REQ-009 Port err  output  1: single-cycle pulse that flags a sequence violation detected in LOCKED.
REQ-010 Port err_cnt  output  8: number of violations detected.
REQ-011 Port expected  output  DWIDTH: next value the monitor expects to see.

Function
REQ-012 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-013 The expected value SHALL be (prev == N-1) ? 0 : prev+1, where prev is the last in-range sample captured.
REQ-014 A sample SHALL be treated as out-of-range when data_in >= N; out-of-range samples never match.
REQ-015 The state machine SHALL have three states: IDLE, ACQUIRE and LOCKED. Reset state is IDLE.
REQ-016 In IDLE, an in-range sample SHALL load prev, clear the match count and move to ACQUIRE; an out-of-range sample leaves the monitor in IDLE.
REQ-017 In ACQUIRE, a matching sample SHALL increment the match count and load prev; when the match count reaches LOCK_LEN, the monitor moves to LOCKED on the same edge.
REQ-018 In ACQUIRE, a mismatching in-range sample SHALL reload prev, clear the match count and stay in ACQUIRE; an out-of-range sample moves to IDLE. Neither case asserts err.
REQ-019 In LOCKED, a matching sample SHALL load prev and keep the monitor in LOCKED.
REQ-020 In LOCKED, a mismatching sample SHALL do all of the following on the capturing edge:
- assert err for exactly one cycle;
- increment err_cnt;
- drop locked;
- if the sample is in range, load prev, clear the match count and go to ACQUIRE;
- if the sample is out of range, go to IDLE.
REQ-021 When sample_en is low, all state and outputs SHALL hold, and err SHALL be 0.
REQ-022 The wrap from N-1 to 0 SHALL be treated as a match and SHALL NOT assert err.
REQ-023 The expected output SHALL always reflect the expected value computed from the current prev; it reads 0 in IDLE.

Reset
REQ-024 rst high SHALL override sample_en and data_in.
REQ-025 On the first rising edge with rst high, the monitor SHALL return to IDLE and clear locked, err, err_cnt, expected, prev and the match count to 0, including when reset arrives mid-LOCKED.
REQ-026 Sampling SHALL resume on the first edge after rst is low.

Configuration
REQ-027 Macro COUNT_MONITOR_ERRCNT_EN, when defined, SHALL implement err_cnt as an 8-bit counter that saturates at 255 and does not wrap.
REQ-028 Without COUNT_MONITOR_ERRCNT_EN, the err_cnt port SHALL remain present and be tied to 0; err and locked behaviour is unchanged.

Verification
Common bench setup: N=9, LOCK_LEN=3, 10 ns clock, rst held for 15 ns then released, sample_en=1 unless stated otherwise.
REQ-029 Stream 0,1,2,3 -> locked goes high after the sample 3 is captured; err stays 0; expected reads 4.
REQ-030 Continue the stream through 8,0,1 -> no err pulse at the wrap and locked stays high.
REQ-031 While locked, present 5 where 4 is expected -> err high for 1 cycle, err_cnt=1 (with the macro), locked=0, state ACQUIRE, expected=6.
REQ-032 While locked, present 12 -> err pulse, state IDLE, expected=0; the next in-range value re-enters ACQUIRE.
REQ-033 Hold sample_en low for 5 cycles with random data_in -> no change to locked, expected or err_cnt; resuming with the correct next value keeps lock.
REQ-034 Assert rst for one edge while locked with err_cnt=3 -> all outputs read 0 after that edge; without the macro, err_cnt reads 0 throughout.

Source files
------------

// File: rtl/count_monitor.sv
// Sequence monitor for a modulo-N counter: locks after LOCK_LEN correct increments, flags breaks.
// Optional macro COUNT_MONITOR_ERRCNT_EN enables the saturating 8-bit violation counter on err_cnt.
module count_monitor #(
   parameter int N        = 9,
   parameter int DWIDTH   = 4,
   parameter int LOCK_LEN = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sample_en,
   input  logic [DWIDTH-1:0] data_in,
   output logic              locked,
   output logic              err,
   output logic [7:0]        err_cnt,
   output logic [DWIDTH-1:0] expected
);

   typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

   // One extra bit so N == 2**DWIDTH still compares correctly.
   localparam logic [DWIDTH:0]   N_W  = (DWIDTH+1)'(N);
   localparam logic [DWIDTH-1:0] LAST = DWIDTH'(N-1);
   localparam logic [3:0]        LOCK = 4'(LOCK_LEN);

   state_t            state, state_nxt;
   logic [DWIDTH-1:0] prev, exp_val;
   logic [3:0]        match_cnt;
   logic              in_range, match, viol;

   assign in_range = {1'b0, data_in} < N_W;
   assign exp_val  = (prev == LAST) ? '0 : prev + 1'b1;
   assign match    = in_range && (data_in == exp_val);

   // Outputs derive only from registers.
   assign locked   = (state == LOCKED);
   assign expected = (state == IDLE) ? '0 : exp_val;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      viol      = 1'b0;
      if (sample_en) begin
         case (state)
            IDLE:    if (in_range) state_nxt = ACQUIRE;
            ACQUIRE: begin
               if (!in_range)                              state_nxt = IDLE;
               else if (match && (match_cnt + 4'd1 == LOCK)) state_nxt = LOCKED;
            end
            LOCKED:  if (!match) begin
               viol      = 1'b1;
               state_nxt = in_range ? ACQUIRE : IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev      <= '0;
         match_cnt <= '0;
         err       <= 1'b0;
      end else begin
         err <= viol;
         // Every in-range sample becomes the new reference, match or not.
         if (sample_en && in_range) prev <= data_in;
         if (sample_en) begin
            case (state)
               IDLE:    match_cnt <= '0;
               ACQUIRE: match_cnt <= match ? match_cnt + 4'd1 : '0;
               LOCKED:  if (!match) match_cnt <= '0;
               default: match_cnt <= '0;
            endcase
         end
      end
   end

`ifdef COUNT_MONITOR_ERRCNT_EN
   logic [7:0] err_cnt_q;
   always_ff @(posedge clk) begin
      if (rst)                               err_cnt_q <= '0;
      else if (viol && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
   end
   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_count_monitor.sv
// Table-driven bench for count_monitor (N=9, LOCK_LEN=3) with an expected-result queue.
module tb_count_monitor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sample_en = 1'b0;
   logic [3:0] data_in = '0;
   logic       locked, err;
   logic [7:0] err_cnt;
   logic [3:0] expected;

   count_monitor #(.N(9), .DWIDTH(4), .LOCK_LEN(3)) dut (
      .clk(clk), .rst(rst), .sample_en(sample_en), .data_in(data_in),
      .locked(locked), .err(err), .err_cnt(err_cnt), .expected(expected)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst, en;
      logic [3:0] d;
      logic       l, e;
      logic [3:0] x;
      logic [7:0] ec;
   } vec_t;

   typedef struct {
      logic       l, e;
      logic [3:0] x;
      logic [7:0] ec;
   } exp_t;

   vec_t vecs[35];
   exp_t sb[$];
   int   n_pass = 0, n_chk = 0;

   function automatic vec_t mk(input logic r, input logic en, input int d,
                               input logic l, input logic e, input int x, input int ec);
      vec_t v;
      v.rst = r; v.en = en; v.d = 4'(d); v.l = l; v.e = e; v.x = 4'(x); v.ec = 8'(ec);
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      n_chk++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, act, req);
   endtask

   task automatic step(input logic r, input logic en, input logic [3:0] d,
                       input logic l, input logic e, input logic [3:0] x,
                       input logic [7:0] ec, input string tag);
      exp_t ex, got;
      ex.l = l; ex.e = e; ex.x = x;
`ifdef COUNT_MONITOR_ERRCNT_EN
      ex.ec = ec;
`else
      ex.ec = 8'd0;
`endif
      rst = r; sample_en = en; data_in = d;
      sb.push_back(ex);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk({tag, ".locked"},   int'(locked),   int'(got.l));
      chk({tag, ".err"},      int'(err),      int'(got.e));
      chk({tag, ".expected"}, int'(expected), int'(got.x));
      chk({tag, ".err_cnt"},  int'(err_cnt),  int'(got.ec));
   endtask

   task automatic run_vecs(input int lo, input int hi);
      for (int i = lo; i <= hi; i++)
         step(vecs[i].rst, vecs[i].en, vecs[i].d, vecs[i].l, vecs[i].e,
              vecs[i].x, vecs[i].ec, $sformatf("v%0d", i));
   endtask

   initial begin
      //            rst en  d  | lck err exp ec
      vecs[0]  = mk(0, 1,  0,   0, 0, 1, 0);
      vecs[1]  = mk(0, 1,  1,   0, 0, 2, 0);
      vecs[2]  = mk(0, 1,  2,   0, 0, 3, 0);
      vecs[3]  = mk(0, 1,  3,   1, 0, 4, 0);
      vecs[4]  = mk(0, 1,  4,   1, 0, 5, 0);
      vecs[5]  = mk(0, 1,  5,   1, 0, 6, 0);
      vecs[6]  = mk(0, 1,  6,   1, 0, 7, 0);
      vecs[7]  = mk(0, 1,  7,   1, 0, 8, 0);
      vecs[8]  = mk(0, 1,  8,   1, 0, 0, 0);
      vecs[9]  = mk(0, 1,  0,   1, 0, 1, 0);
      vecs[10] = mk(0, 1,  1,   1, 0, 2, 0);
      vecs[11] = mk(0, 1,  2,   1, 0, 3, 0);
      vecs[12] = mk(0, 1,  3,   1, 0, 4, 0);
      vecs[13] = mk(0, 1,  5,   0, 1, 6, 1);
      vecs[14] = mk(0, 1,  6,   0, 0, 7, 1);
      vecs[15] = mk(0, 1,  7,   0, 0, 8, 1);
      vecs[16] = mk(0, 1,  8,   1, 0, 0, 1);
      vecs[17] = mk(0, 1, 12,   0, 1, 0, 2);
      vecs[18] = mk(0, 1, 12,   0, 0, 0, 2);
      vecs[19] = mk(0, 1,  4,   0, 0, 5, 2);
      vecs[20] = mk(0, 1,  5,   0, 0, 6, 2);
      vecs[21] = mk(0, 1,  6,   0, 0, 7, 2);
      vecs[22] = mk(0, 1,  7,   1, 0, 8, 2);
      vecs[23] = mk(0, 1,  8,   1, 0, 0, 2);
      vecs[24] = mk(0, 1,  3,   0, 1, 4, 3);
      vecs[25] = mk(0, 1,  4,   0, 0, 5, 3);
      vecs[26] = mk(0, 1,  5,   0, 0, 6, 3);
      vecs[27] = mk(0, 1,  6,   1, 0, 7, 3);
      vecs[28] = mk(1, 1,  7,   0, 0, 0, 0);
      vecs[29] = mk(0, 1,  0,   0, 0, 1, 0);
      vecs[30] = mk(0, 1,  5,   0, 0, 6, 0);
      vecs[31] = mk(0, 1,  9,   0, 0, 0, 0);
      vecs[32] = mk(0, 1, 15,   0, 0, 0, 0);
      vecs[33] = mk(0, 1,  8,   0, 0, 0, 0);
      vecs[34] = mk(0, 1,  0,   0, 0, 1, 0);

      // Reset with sample_en high and in-range data: reset must win.
      step(1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 8'd0, "rst0");
      step(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 8'd0, "rst1");

      run_vecs(0, 22);

      // sample_en low with random data: everything holds, err stays 0.
      for (int k = 0; k < 5; k++)
         step(1'b0, 1'b0, 4'($urandom_range(0, 15)), 1'b1, 1'b0, 4'd8, 8'd2,
              $sformatf("hold%0d", k));

      run_vecs(23, 34);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: bench did not complete, got %0d checks", n_chk);
      $fatal(1);
   end

endmodule
